// File: rtl/audio_sample_tx.sv
// audio_sample_tx
// Serializing end of the audio playback path. A sample word is loaded at
// each LR-frame boundary and shifted out MSB first as a left-justified
// stream. The block also generates the bit clock and the LR clock.
//
// Handshake with the playback address sequencer:
//   INIT        : level enable. Dropping it returns to IDLE on the next edge.
//   INIT_FINISH : high while streaming (RUN), after INIT_FRAMES silent frames.
//   data_over   : one-cycle pulse after each load of sample_data.
//                 The sequencer then has a full frame to present the next word.
//
// Ports:
//   Clk, Reset (sync, active-low), INIT, sample_data -> inputs
//   INIT_FINISH, data_over, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT -> outputs
//   dbg_state -> current FSM state (0 IDLE, 1 WARMUP, 2 RUN)
//
// Build option AUDIO_TX_STEREO_EN:
//   defined   : sample_data is 2*SAMPLE_W wide; the upper half goes to the
//               left channel and the lower half to the right channel.
//   undefined : sample_data is SAMPLE_W wide and is sent on both channels.
module audio_sample_tx #(
  parameter int SAMPLE_W    = 16,
  parameter int BCLK_DIV    = 4,
  parameter int INIT_FRAMES = 8,
`ifdef AUDIO_TX_STEREO_EN
  localparam int DIN_W      = 2 * SAMPLE_W
`else
  localparam int DIN_W      = SAMPLE_W
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             INIT,
  output logic             INIT_FINISH,
  input  logic [DIN_W-1:0] sample_data,
  output logic             data_over,
  output logic             AUD_BCLK,
  output logic             AUD_DACLRCK,
  output logic             AUD_DACDAT,
  output logic [1:0]       dbg_state
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SAMPLE_W);
  localparam int FRM_W = $clog2(INIT_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                bclk_q, bclk_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRM_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] right_q, right_d;
  logic                data_over_q, data_over_d;

  logic                div_wrap;
  logic                bclk_fall;
  logic                frame_end;
  logic                do_load;
  logic [SAMPLE_W-1:0] left_word;
  logic [SAMPLE_W-1:0] right_word;

`ifdef AUDIO_TX_STEREO_EN
  assign left_word  = sample_data[DIN_W-1 -: SAMPLE_W];
  assign right_word = sample_data[SAMPLE_W-1:0];
`else
  assign left_word  = sample_data;
  assign right_word = sample_data;
`endif

  assign div_wrap  = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
  // A wrap while BCLK is high is the 1->0 toggle: the bit boundary.
  assign bclk_fall = div_wrap && bclk_q;
  assign frame_end = bclk_fall && (bit_cnt_q == BIT_W'(2 * SAMPLE_W - 1));

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bclk_d      = bclk_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    shift_d     = shift_q;
    right_d     = right_q;
    data_over_d = 1'b0;
    do_load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (INIT) begin
          state_d     = ST_WARMUP;
          div_cnt_d   = '0;
          bclk_d      = 1'b0;
          bit_cnt_d   = '0;
          frame_cnt_d = '0;
          shift_d     = '0;
          right_d     = '0;
        end
      end
      ST_WARMUP, ST_RUN: begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
        if (div_wrap) bclk_d = ~bclk_q;
        if (bclk_fall) begin
          bit_cnt_d = frame_end ? '0 : bit_cnt_q + BIT_W'(1);
          // Entering the right half of the frame reloads the right copy.
          if (bit_cnt_q == BIT_W'(SAMPLE_W - 1)) shift_d = right_q;
          else shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
        end
        if (frame_end) begin
          if (state_q == ST_RUN) begin
            do_load = 1'b1;
          end else begin
            // Saturating count of completed silent frames.
            if (frame_cnt_q != FRM_W'(INIT_FRAMES))
              frame_cnt_d = frame_cnt_q + FRM_W'(1);
            if (frame_cnt_q >= FRM_W'(INIT_FRAMES - 1)) begin
              state_d = ST_RUN;
              do_load = 1'b1;
            end
          end
        end
        if (do_load) begin
          shift_d     = left_word;
          right_d     = right_word;
          data_over_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping INIT wins over everything, including a load edge.
    if (!INIT) begin
      state_d     = ST_IDLE;
      div_cnt_d   = '0;
      bclk_d      = 1'b0;
      bit_cnt_d   = '0;
      frame_cnt_d = '0;
      shift_d     = '0;
      right_d     = '0;
      data_over_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      shift_q     <= '0;
      right_q     <= '0;
      data_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      shift_q     <= shift_d;
      right_q     <= right_d;
      data_over_q <= data_over_d;
    end
  end

  assign INIT_FINISH = (state_q == ST_RUN);
  assign data_over   = data_over_q;
  assign AUD_BCLK    = bclk_q;
  assign AUD_DACLRCK = (state_q != ST_IDLE) && (bit_cnt_q < BIT_W'(SAMPLE_W));
  assign AUD_DACDAT  = shift_q[SAMPLE_W-1];
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_audio_sample_tx.sv
// Directed testbench for audio_sample_tx with default parameters
// (SAMPLE_W=16, BCLK_DIV=4, INIT_FRAMES=8): 8-cycle bits, 256-cycle frames,
// 2048-cycle warm-up.
module tb_audio_sample_tx;

  localparam int SAMPLE_W = 16;
`ifdef AUDIO_TX_STEREO_EN
  localparam int DIN_W = 2 * SAMPLE_W;
`else
  localparam int DIN_W = SAMPLE_W;
`endif
  localparam int BIT_CYC   = 8;
  localparam int FRAME_CYC = 256;
  localparam int WARM_CYC  = 2048;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             init;
  logic             init_finish;
  logic [DIN_W-1:0] sample_data;
  logic             data_over;
  logic             aud_bclk;
  logic             aud_daclrck;
  logic             aud_dacdat;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  audio_sample_tx dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .INIT        (init),
    .INIT_FINISH (init_finish),
    .sample_data (sample_data),
    .data_over   (data_over),
    .AUD_BCLK    (aud_bclk),
    .AUD_DACLRCK (aud_daclrck),
    .AUD_DACDAT  (aud_dacdat),
    .dbg_state   (dbg_state)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".init_finish"}, init_finish, 1'b0);
    check({tag, ".data_over"},   data_over,   1'b0);
    check({tag, ".bclk"},        aud_bclk,    1'b0);
    check({tag, ".lrck"},        aud_daclrck, 1'b0);
    check({tag, ".dat"},         aud_dacdat,  1'b0);
    check({tag, ".state"},       dbg_state,   2'd0);
  endtask

  // Called just after the edge that entered WARMUP. Ends just after the
  // edge that completes warm-up (the first load edge).
  task automatic check_warmup();
    for (int c = 0; c < WARM_CYC; c++) begin
      check("warm.dat",       aud_dacdat,  1'b0);
      check("warm.data_over", data_over,   1'b0);
      check("warm.fin",       init_finish, 1'b0);
      check("warm.bclk",      aud_bclk,    ((c % BIT_CYC) >= 4) ? 1'b1 : 1'b0);
      step();
    end
    check("warm.done_fin", init_finish, 1'b1);
    check("warm.done_st",  dbg_state,   2'd2);
  endtask

  // Called just after a load edge; checks a full frame carrying 'word' and
  // presents 'next_word' one cycle after the data_over pulse.
  task automatic run_frame(input logic [DIN_W-1:0] word, input logic [DIN_W-1:0] next_word);
    logic [SAMPLE_W-1:0] l_w, r_w;
    int b;
    logic exp_dat;
`ifdef AUDIO_TX_STEREO_EN
    l_w = word[DIN_W-1 -: SAMPLE_W];
    r_w = word[SAMPLE_W-1:0];
`else
    l_w = word;
    r_w = word;
`endif
    for (int c = 0; c < FRAME_CYC; c++) begin
      b = c / BIT_CYC;
      exp_dat = (b < SAMPLE_W) ? l_w[SAMPLE_W-1-b] : r_w[2*SAMPLE_W-1-b];
      check("run.dat",       aud_dacdat,  exp_dat);
      check("run.lrck",      aud_daclrck, (b < SAMPLE_W) ? 1'b1 : 1'b0);
      check("run.bclk",      aud_bclk,    ((c % BIT_CYC) >= 4) ? 1'b1 : 1'b0);
      check("run.data_over", data_over,   (c == 0) ? 1'b1 : 1'b0);
      check("run.fin",       init_finish, 1'b1);
      if (c == 1) sample_data = next_word;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    init = 1'b1;
    sample_data = DIN_W'(16'hA5C3);

    // Reset overrides INIT.
    repeat (10) step();
    check_all_zero("reset");

    rst_n = 1'b1;
    step();
    check("rel.state", dbg_state, 2'd1);

    check_warmup();
    run_frame(DIN_W'(16'hA5C3), DIN_W'(16'h0001));
    run_frame(DIN_W'(16'h0001), DIN_W'(16'h8000));
`ifdef AUDIO_TX_STEREO_EN
    run_frame(DIN_W'(16'h8000), DIN_W'(32'h8000_0001));
    run_frame(DIN_W'(32'h8000_0001), DIN_W'(16'h1234));
`else
    run_frame(DIN_W'(16'h8000), DIN_W'(16'h1234));
`endif

    // Drop INIT mid-frame.
    repeat (100) step();
    init = 1'b0;
    step();
    check_all_zero("drop");

    // Reassert: full warm-up again.
    init = 1'b1;
    step();
    check("reinit.state", dbg_state, 2'd1);
    check_warmup();
    run_frame(DIN_W'(16'h1234), DIN_W'(16'h5A5A));

    // INIT low on a load edge: IDLE wins, no data_over pulse.
    repeat (FRAME_CYC - 1) step();
    init = 1'b0;
    step();
    check_all_zero("loaddrop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
